fib_job_scheduler: RTL and testbench
====================================

// Module: fib_job_scheduler
// PURPOSE
//   Queues Fibonacci job requests (index N) from a host and runs them one at a time on the
//   shared sequencer + register-file/ALU datapath. For each job it loads N, resets and starts
//   the sequencer, waits for DONE, then captures the result and returns it over a
//   valid/ready port. It sits between the host interface and the Fibonacci sequencer.
// PARAMETERS
//   N_W          8     width of job index N
//   DATA_W       16    width of datapath result
//   FIFO_DEPTH   4     request queue entries (power of 2, >=2)
//   TIMEOUT_CYC  1024  watchdog limit in WAIT state (used only with FIB_TIMEOUT_EN)
// PORTS
//   CLK          in   1        clock, all state on rising edge
//   RST          in   1        asynchronous reset, active-high
//   REQ_VALID    in   1        host job request valid
//   REQ_READY    out  1        queue not full
//   REQ_N        in   N_W      job index N
//   RES_VALID    out  1        result valid
//   RES_READY    in   1        host accepts result
//   RES_DATA     out  DATA_W   captured result
//   RES_TIMEOUT  out  1        result aborted by watchdog (0 when FIB_TIMEOUT_EN undefined)
//   LOAD_EN      out  1        write LOAD_DATA into datapath N register
//   LOAD_DATA    out  N_W      N for current job
//   SEQ_RST      out  1        reset to sequencer (sequencer has terminal DONE state)
//   SEQ_START    out  1        START pulse to sequencer
//   SEQ_DONE     in   1        sequencer DONE (level)
//   RESULT_IN    in   DATA_W   datapath result bus, valid while SEQ_DONE=1
//   BUSY         out  1        1 in any state other than IDLE
// BEHAVIOUR
//   - Reset: state=IDLE, FIFO empty, REQ_READY=1, RES_VALID=0, RES_DATA=0, RES_TIMEOUT=0,
//     LOAD_EN=0, LOAD_DATA=0, SEQ_START=0, SEQ_RST=1, BUSY=0. All outputs registered/Moore.
//   - Request queue: push when REQ_VALID&&REQ_READY; REQ_READY=!full. Push and pop in the
//     same cycle when full is legal only as pop-first (push accepted only if REQ_READY was 1).
//     Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
//   - FSM (one state per cycle unless noted):
//     IDLE    : SEQ_RST=1. FIFO non-empty -> LOAD.
//     LOAD    : SEQ_RST=1, LOAD_EN=1, LOAD_DATA=FIFO head; pop head -> KICK.
//     KICK    : SEQ_RST=0, SEQ_START=1 (exactly one cycle) -> WAIT.
//     WAIT    : SEQ_RST=0. SEQ_DONE=1 -> CAPTURE; watchdog expiry -> CAPTURE (timeout).
//     CAPTURE : RES_DATA<=RESULT_IN (or 0 on timeout), RES_TIMEOUT<=timeout; SEQ_RST=1 -> OUTPUT.
//     OUTPUT  : RES_VALID=1, SEQ_RST=1; held with RES_DATA stable until RES_READY=1 -> IDLE.
//   - SEQ_DONE outside WAIT is ignored. Min job latency request->RES_VALID: 4 cycles + sequencer
//     run time. Back-to-back queued jobs: IDLE->LOAD adds 1 cycle between jobs.
//   - New requests accepted in every state, including OUTPUT backpressure.
//   - RST mid-job: FSM to IDLE, queued jobs discarded, SEQ_RST asserted immediately.
//   - N=0 is passed through unchanged; result is whatever the sequencer returns.
// CONFIGURATION
//   FIB_TIMEOUT_EN defined: counter cleared in KICK, increments each WAIT cycle; reaching
//     TIMEOUT_CYC-1 without SEQ_DONE forces CAPTURE with RES_TIMEOUT=1, RES_DATA=0.
//     SEQ_DONE in the expiry cycle wins (normal result).
//   FIB_TIMEOUT_EN undefined: no counter, WAIT exits only on SEQ_DONE, RES_TIMEOUT tied 0.
// TESTING
//   1 Single job N=5, sequencer model DONE after 20 cycles, RESULT_IN=5 -> one LOAD_EN with
//     LOAD_DATA=5, one SEQ_START pulse, RES_VALID with RES_DATA=5, RES_TIMEOUT=0.
//   2 Push 5 jobs (N=1..5) back-to-back with FIFO_DEPTH=4, job 1 in flight -> REQ_READY drops
//     when 4 queued; results returned in order 1,1,2,3,5.
//   3 Hold RES_READY=0 for 10 cycles in OUTPUT -> RES_VALID/RES_DATA stable, no LOAD_EN,
//     SEQ_RST=1 throughout; release -> next job starts 2 cycles later.
//   4 FIB_TIMEOUT_EN, TIMEOUT_CYC=16, SEQ_DONE never asserted -> RES_VALID after timeout with
//     RES_TIMEOUT=1, RES_DATA=0; next job runs normally.
//   5 Assert RST during WAIT with 2 jobs queued -> all outputs at reset values same cycle,
//     REQ_READY=1, no result emitted after release.
//   6 Spurious SEQ_DONE pulse in IDLE -> ignored, BUSY stays 0, RES_VALID stays 0.

Source files
------------

// File: rtl/fib_job_scheduler_if.sv
// fib_job_scheduler_if: host request/result handshakes plus sequencer/datapath control for fib_job_scheduler
interface fib_job_scheduler_if #(
  parameter int N_W    = 8,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [N_W-1:0]    req_n;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_timeout;
  logic              load_en;
  logic [N_W-1:0]    load_data;
  logic              seq_rst;
  logic              seq_start;
  logic              seq_done;
  logic [DATA_W-1:0] result_in;
  logic              busy;
  modport slave (
    input  req_valid, req_n, res_ready, seq_done, result_in,
    output req_ready, res_valid, res_data, res_timeout, load_en, load_data, seq_rst, seq_start, busy
  );
  modport master (
    output req_valid, req_n, res_ready, seq_done, result_in,
    input  req_ready, res_valid, res_data, res_timeout, load_en, load_data, seq_rst, seq_start, busy
  );
endinterface

// File: rtl/fib_job_scheduler.sv
// fib_job_scheduler: queues Fibonacci jobs and runs them one at a time on the sequencer; optional watchdog via FIB_TIMEOUT_EN
module fib_job_scheduler #(
  parameter int N_W         = 8,
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic               i_clk,
  input logic               i_rst,
  fib_job_scheduler_if.slave io
);
  localparam int AW = $clog2(FIFO_DEPTH);
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYC < 2) begin : g_param_chk
    $error("fib_job_scheduler: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 2");
  end
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KICK, S_WAIT, S_CAPT, S_OUT} state_t;
  state_t            r_state, w_next;
  logic [N_W-1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wp, r_rp;
  logic [AW:0]       r_count;
  logic [DATA_W-1:0] r_res_data;
  logic              r_res_to;
  logic              w_full, w_push, w_pop, w_expire;
  assign w_full = r_count == (AW+1)'(FIFO_DEPTH);
  assign w_push = io.req_valid && !w_full;
  assign w_pop  = r_state == S_LOAD;
  // queue storage; a full queue refuses the push even if the head pops this cycle
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wp] <= io.req_n;
  // queue pointers and occupancy
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
`ifdef FIB_TIMEOUT_EN
  localparam int TC_W = $clog2(TIMEOUT_CYC);
  logic [TC_W-1:0] r_tcnt;
  // watchdog: cleared on the kick, counts every cycle spent waiting for DONE
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_tcnt <= '0;
    else if (r_state == S_KICK) r_tcnt <= '0;
    else if (r_state == S_WAIT) r_tcnt <= r_tcnt + TC_W'(1);
  assign w_expire = r_state == S_WAIT && !io.seq_done && r_tcnt == TC_W'(TIMEOUT_CYC - 1);
`else
  assign w_expire = 1'b0;
`endif
  // state register; reset drops straight to IDLE so SEQ_RST asserts immediately
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= S_IDLE;
    else r_state <= w_next;
  // next-state logic; DONE is only looked at while waiting
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = r_count != '0 ? S_LOAD : S_IDLE;
      S_LOAD:  w_next = S_KICK;
      S_KICK:  w_next = S_WAIT;
      S_WAIT:  w_next = (io.seq_done || w_expire) ? S_CAPT : S_WAIT;
      S_CAPT:  w_next = S_OUT;
      S_OUT:   w_next = io.res_ready ? S_IDLE : S_OUT;
      default: w_next = S_IDLE;
    endcase
  end
  // result capture on leaving WAIT while RESULT_IN is still valid; a watchdog abort returns zero
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_res_data <= '0;
      r_res_to   <= 1'b0;
    end else if (r_state == S_WAIT && (io.seq_done || w_expire)) begin
      r_res_data <= io.seq_done ? io.result_in : '0;
      r_res_to   <= !io.seq_done;
    end
  assign io.req_ready   = !w_full;
  assign io.busy        = r_state != S_IDLE;
  assign io.seq_rst     = !(r_state == S_KICK || r_state == S_WAIT);
  assign io.seq_start   = r_state == S_KICK;
  assign io.load_en     = r_state == S_LOAD;
  assign io.load_data   = r_state == S_LOAD ? r_mem[r_rp] : '0;
  assign io.res_valid   = r_state == S_OUT;
  assign io.res_data    = r_res_data;
  assign io.res_timeout = r_res_to;
endmodule

// File: tb/tb_fib_job_scheduler.sv
// tb_fib_job_scheduler: directed bench for fib_job_scheduler with a small sequencer/datapath model
module tb_fib_job_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fib_job_scheduler_if #(.N_W(8), .DATA_W(16)) dut_if ();
  fib_job_scheduler #(.N_W(8), .DATA_W(16), .FIFO_DEPTH(4), .TIMEOUT_CYC(16)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .io   (dut_if)
  );
  int n_chk = 0;
  int n_pass = 0;
  int n_load = 0;
  int n_start = 0;
  logic [7:0] last_ld = '0;
  logic spur = 1'b0;
  logic hang = 1'b0;
  int run_len = 20;
  logic m_run = 1'b0;
  logic m_done = 1'b0;
  int m_cnt = 0;
  logic [7:0] m_n = '0;
  function automatic logic [15:0] fib(input logic [7:0] n);
    logic [15:0] a, b, t;
    a = 16'd0;
    b = 16'd1;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction
  assign dut_if.seq_done  = m_done | spur;
  assign dut_if.result_in = fib(m_n);
  always @(posedge clk) begin
    if (dut_if.load_en) m_n <= dut_if.load_data;
    if (dut_if.seq_rst) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else if (dut_if.seq_start) begin
      m_run <= 1'b1;
      m_cnt <= 0;
    end else if (m_run && !m_done && !hang) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == run_len - 1) m_done <= 1'b1;
    end
  end
  always @(negedge clk) begin
    if (dut_if.load_en) begin
      n_load  <= n_load + 1;
      last_ld <= dut_if.load_data;
    end
    if (dut_if.seq_start) n_start <= n_start + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic push(input logic [7:0] n);
    for (int t = 0; t < 200 && !dut_if.req_ready; t++) @(negedge clk);
    dut_if.req_valid = 1'b1;
    dut_if.req_n     = n;
    @(negedge clk);
    dut_if.req_valid = 1'b0;
  endtask
  task automatic expect_res(input string tag, input logic [15:0] d, input logic t);
    for (int w = 0; w < 300 && !dut_if.res_valid; w++) @(negedge clk);
    chk({tag, "_valid"}, 32'(dut_if.res_valid), 32'd1);
    chk({tag, "_data"}, 32'(dut_if.res_data), 32'(d));
    chk({tag, "_to"}, 32'(dut_if.res_timeout), 32'(t));
    dut_if.res_ready = 1'b1;
    @(negedge clk);
    dut_if.res_ready = 1'b0;
  endtask
  initial begin
    int l0, s0, seen;
    logic [15:0] exp2 [5];
    exp2[0] = 16'd1; exp2[1] = 16'd1; exp2[2] = 16'd2; exp2[3] = 16'd3; exp2[4] = 16'd5;
    dut_if.req_valid = 1'b0;
    dut_if.req_n     = '0;
    dut_if.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(dut_if.req_ready), 32'd1);
    chk("rst_valid", 32'(dut_if.res_valid), 32'd0);
    chk("rst_data", 32'(dut_if.res_data), 32'd0);
    chk("rst_to", 32'(dut_if.res_timeout), 32'd0);
    chk("rst_load", {23'd0, dut_if.load_en, dut_if.load_data}, 32'd0);
    chk("rst_seq", {30'd0, dut_if.seq_rst, dut_if.seq_start}, 32'd2);
    chk("rst_busy", 32'(dut_if.busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    seen = 0;
    repeat (4) begin
      if (dut_if.busy || dut_if.res_valid) seen = 1;
      @(negedge clk);
    end
    chk("spur_idle", 32'(seen), 32'd0);
    l0 = n_load;
    s0 = n_start;
    push(8'd5);
    expect_res("t1", 16'd5, 1'b0);
    chk("t1_loads", 32'(n_load - l0), 32'd1);
    chk("t1_ld_data", 32'(last_ld), 32'd5);
    chk("t1_starts", 32'(n_start - s0), 32'd1);
    for (int i = 1; i <= 5; i++) push(8'(i));
    chk("t2_full", 32'(dut_if.req_ready), 32'd0);
    for (int i = 0; i < 5; i++) expect_res($sformatf("t2_job%0d", i + 1), exp2[i], 1'b0);
    push(8'd0);
    expect_res("n0", 16'd0, 1'b0);
    chk("n0_ld_data", 32'(last_ld), 32'd0);
    push(8'd6);
    push(8'd7);
    for (int w = 0; w < 300 && !dut_if.res_valid; w++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t3_hold%0d", i), {13'd0, dut_if.res_valid, dut_if.seq_rst, dut_if.load_en, dut_if.res_data}, {13'd0, 3'b110, 16'd8});
      @(negedge clk);
    end
    dut_if.res_ready = 1'b1;
    @(negedge clk);
    dut_if.res_ready = 1'b0;
    chk("t3_gap", 32'(dut_if.load_en), 32'd0);
    @(negedge clk);
    chk("t3_next_load", {23'd0, dut_if.load_en, dut_if.load_data}, {23'd0, 1'b1, 8'd7});
    expect_res("t3_next", 16'd13, 1'b0);
`ifdef FIB_TIMEOUT_EN
    hang = 1'b1;
    push(8'd3);
    expect_res("t4_tmo", 16'd0, 1'b1);
    hang = 1'b0;
    push(8'd4);
    expect_res("t4_after", 16'd3, 1'b0);
`endif
    push(8'd2);
    for (int w = 0; w < 100 && !(dut_if.busy && !dut_if.seq_rst && !dut_if.seq_start); w++) @(negedge clk);
    push(8'd3);
    push(8'd4);
    chk("t5_in_wait", {30'd0, dut_if.busy, dut_if.seq_rst}, 32'd2);
    rst = 1'b1;
    #1;
    chk("t5_ready", 32'(dut_if.req_ready), 32'd1);
    chk("t5_outs", {26'd0, dut_if.busy, dut_if.seq_rst, dut_if.seq_start, dut_if.load_en, dut_if.res_valid, dut_if.res_timeout}, 32'b010000);
    chk("t5_data", 32'(dut_if.res_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (dut_if.res_valid || dut_if.load_en || dut_if.busy) seen = 1;
    end
    chk("t5_no_result", 32'(seen), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
